// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the AHB-Lite burst initiator.
package ahb_lite_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BURST,
        ST_LAST_DATA,
        ST_RSP,
        ST_ERR2
    } state_t;

    // A word beat starting a new 1 KB page must restart the burst with NONSEQ.
    function automatic logic crosses_1k(input logic [9:0] addr_low);
        return addr_low == 10'd0;
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns one (addr, len, dir) command into a SINGLE/INCR word burst
// with pipelined address/data phases, wait states, BUSY insertion, 1 KB split and ERROR drain.
module ahb_lite_master
    import ahb_lite_master_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         MAX_LEN_W = 4,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [MAX_LEN_W-1:0] cmd_len,
    input  logic                 wr_valid,
    input  logic [31:0]          wr_data,
    output logic                 wr_ready,
    output logic                 rd_valid,
    output logic [31:0]          rd_data,
    output logic                 rd_last,
    output logic                 rsp_valid,
    output logic                 rsp_err,
    output logic [ADDR_W-1:0]    haddr,
    output logic [1:0]           htrans,
    output logic                 hwrite,
    output logic [2:0]           hsize,
    output logic [2:0]           hburst,
    output logic [3:0]           hprot,
    output logic                 hmastlock,
    output logic [31:0]          hwdata,
    input  logic [31:0]          hrdata,
    input  logic                 hready,
    input  logic                 hresp
);

    localparam int CNT_W = MAX_LEN_W + 1;

    state_t               state;
    logic [MAX_LEN_W-1:0] len_q;
    logic [CNT_W-1:0]     issued;
    logic [CNT_W-1:0]     completed;
    logic [CNT_W-1:0]     total;
    logic                 nonseq_q;
    logic                 dp_valid;
    logic                 committed;
    logic                 err_done;
    logic                 want;
    logic                 run;
    logic                 addr_go;
    logic                 a_acc;
    logic                 d_done;
    logic                 err_resp;
    logic                 err1;
    logic                 last_issue;
    logic                 drain;
    logic [ADDR_W-1:0]    next_addr;

    assign hsize     = HSIZE_WORD;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;

    assign total      = {1'b0, len_q} + CNT_W'(1);
    assign want       = (state == ST_ADDR) || (state == ST_BURST);
    assign run        = want || (state == ST_LAST_DATA);
    assign err_resp   = (hresp == HRESP_ERROR);
    // An address already shown to a stalled slave must stay on the bus even if wr_valid drops.
    assign addr_go    = want && (!hwrite || wr_valid || committed);
    assign a_acc      = addr_go && hready;
    assign d_done     = dp_valid && hready;
    assign err1       = run && dp_valid && err_resp && !hready;
    assign last_issue = (issued + CNT_W'(1)) == total;
    assign next_addr  = haddr + ADDR_W'(4);
    assign drain      = (state == ST_ERR2) && err_done && hwrite && (issued != total);

    assign wr_ready = (a_acc && hwrite) || (drain && wr_valid);
    assign rd_valid = run && !hwrite && d_done && !err_resp;
    assign rd_data  = hrdata;
    assign rd_last  = rd_valid && (completed == {1'b0, len_q});

    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (latch).
    always_comb begin
        htrans = HTRANS_IDLE;
        if (addr_go)
            htrans = nonseq_q ? HTRANS_NONSEQ : HTRANS_SEQ;
        else if (want && issued != '0)
            htrans = HTRANS_BUSY;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= ST_IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hburst    <= HBURST_SINGLE;
            hwdata    <= '0;
            len_q     <= '0;
            issued    <= '0;
            completed <= '0;
            nonseq_q  <= 1'b0;
            dp_valid  <= 1'b0;
            committed <= 1'b0;
            err_done  <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            dp_valid  <= hready ? a_acc : dp_valid;
            committed <= addr_go && !hready;

            if (a_acc) begin
                issued   <= issued + CNT_W'(1);
                nonseq_q <= crosses_1k(next_addr[9:0]);
                if (!last_issue)
                    haddr <= next_addr;
                if (hwrite)
                    hwdata <= wr_data;
            end
            if (run && d_done && !err_resp)
                completed <= completed + CNT_W'(1);

            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state     <= ST_ADDR;
                        cmd_ready <= 1'b0;
                        haddr     <= cmd_addr & ~ADDR_W'(3);
                        hwrite    <= cmd_write;
                        hburst    <= (cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
                        len_q     <= cmd_len;
                        issued    <= '0;
                        completed <= '0;
                        nonseq_q  <= 1'b1;
                        err_done  <= 1'b0;
                    end
                end
                ST_ADDR, ST_BURST, ST_LAST_DATA: begin
                    if (err1 || (d_done && err_resp)) begin
                        state    <= ST_ERR2;
                        err_done <= d_done;
                    end else if (state == ST_LAST_DATA) begin
                        if (d_done) begin
                            state     <= ST_RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                        end
                    end else if (a_acc) begin
                        state <= last_issue ? ST_LAST_DATA : ST_BURST;
                    end
                end
                ST_ERR2: begin
                    // Wait for the second ERROR cycle, then swallow any write beats still owed.
                    if (!err_done) begin
                        if (hready)
                            err_done <= 1'b1;
                    end else if (drain) begin
                        if (wr_valid)
                            issued <= issued + CNT_W'(1);
                    end else begin
                        state     <= ST_RSP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end
                end
                ST_RSP: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed self-checking bench for ahb_lite_master: bus responses are driven per cycle from one initial block.
module tb_ahb_lite_master;

    logic        clk_clk;
    logic        reset_reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int checks = 0;
    int errors = 0;

    ahb_lite_master #(
        .ADDR_W(32),
        .MAX_LEN_W(4),
        .HPROT_VAL(4'b0011)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_last(rd_last),
        .rsp_valid(rsp_valid),
        .rsp_err(rsp_err),
        .haddr(haddr),
        .htrans(htrans),
        .hwrite(hwrite),
        .hsize(hsize),
        .hburst(hburst),
        .hprot(hprot),
        .hmastlock(hmastlock),
        .hwdata(hwdata),
        .hrdata(hrdata),
        .hready(hready),
        .hresp(hresp)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked 1 time unit later.
    task automatic cyc();
        @(negedge clk_clk);
    endtask

    task automatic cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_htrans", htrans, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_hsize", hsize, 3'b010);
        chk("rst_hprot", hprot, 4'b0011);
        chk("rst_hburst", hburst, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_hmastlock", hmastlock, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        cyc(); cyc();
        reset_reset_n = 1'b1;

        // Read, 4 beats from 0x100, zero wait states
        cyc(); cmd(1'b0, 32'h100, 4'd3); #1;
        chk("A_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("A_htrans0", htrans, 2); chk("A_haddr0", haddr, 32'h100);
        chk("A_hburst", hburst, 1); chk("A_hwrite", hwrite, 0); chk("A_busy_ready", cmd_ready, 0);
        cyc(); hrdata = 32'hA0; #1;
        chk("A_htrans1", htrans, 3); chk("A_haddr1", haddr, 32'h104);
        chk("A_rv0", rd_valid, 1); chk("A_rd0", rd_data, 32'hA0); chk("A_rl0", rd_last, 0);
        cyc(); hrdata = 32'hA1; #1;
        chk("A_htrans2", htrans, 3); chk("A_haddr2", haddr, 32'h108); chk("A_rd1", rd_data, 32'hA1);
        cyc(); hrdata = 32'hA2; #1;
        chk("A_haddr3", haddr, 32'h10C); chk("A_rv2", rd_valid, 1); chk("A_rl2", rd_last, 0);
        cyc(); hrdata = 32'hA3; #1;
        chk("A_htrans_end", htrans, 0); chk("A_rv3", rd_valid, 1);
        chk("A_rd3", rd_data, 32'hA3); chk("A_rl3", rd_last, 1);
        cyc(); hrdata = '0; #1;
        chk("A_rsp_valid", rsp_valid, 1); chk("A_rsp_err", rsp_err, 0); chk("A_rv_after", rd_valid, 0);

        // Single write to 0x40 with two wait states
        cyc(); cmd(1'b1, 32'h40, 4'd0); wr_valid = 1'b1; wr_data = 32'hDEADBEEF; #1;
        chk("B_cmd_ready", cmd_ready, 1); chk("B_rsp_clear", rsp_valid, 0);
        cyc(); cmd_valid = 1'b0; #1;
        chk("B_htrans", htrans, 2); chk("B_haddr", haddr, 32'h40);
        chk("B_hburst", hburst, 0); chk("B_hwrite", hwrite, 1); chk("B_wr_ready", wr_ready, 1);
        cyc(); wr_valid = 1'b0; hready = 1'b0; #1;
        chk("B_hwdata_w1", hwdata, 32'hDEADBEEF); chk("B_wr_ready_w1", wr_ready, 0); chk("B_htrans_w1", htrans, 0);
        cyc(); #1;
        chk("B_hwdata_w2", hwdata, 32'hDEADBEEF);
        cyc(); hready = 1'b1; #1;
        chk("B_hwdata_w3", hwdata, 32'hDEADBEEF); chk("B_no_early_rsp", rsp_valid, 0);
        cyc(); #1;
        chk("B_rsp_valid", rsp_valid, 1); chk("B_rsp_err", rsp_err, 0);

        // Write, 4 beats, source stalls for two cycles before beat 2
        cyc(); cmd(1'b1, 32'h200, 4'd3); wr_valid = 1'b1; wr_data = 32'h11; #1;
        chk("C_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("C_htrans0", htrans, 2); chk("C_haddr0", haddr, 32'h200);
        chk("C_hburst", hburst, 1); chk("C_wr_ready0", wr_ready, 1);
        cyc(); wr_data = 32'h22; #1;
        chk("C_htrans1", htrans, 3); chk("C_haddr1", haddr, 32'h204);
        chk("C_wr_ready1", wr_ready, 1); chk("C_hwdata0", hwdata, 32'h11);
        cyc(); wr_valid = 1'b0; #1;
        chk("C_busy1", htrans, 1); chk("C_busy1_addr", haddr, 32'h208);
        chk("C_busy1_wr_ready", wr_ready, 0); chk("C_hwdata1", hwdata, 32'h22);
        cyc(); #1;
        chk("C_busy2", htrans, 1); chk("C_busy2_addr", haddr, 32'h208);
        cyc(); wr_valid = 1'b1; wr_data = 32'h33; #1;
        chk("C_htrans2", htrans, 3); chk("C_haddr2", haddr, 32'h208); chk("C_wr_ready2", wr_ready, 1);
        cyc(); wr_data = 32'h44; #1;
        chk("C_htrans3", htrans, 3); chk("C_haddr3", haddr, 32'h20C); chk("C_hwdata2", hwdata, 32'h33);
        cyc(); wr_valid = 1'b0; #1;
        chk("C_htrans_end", htrans, 0); chk("C_hwdata3", hwdata, 32'h44);
        cyc(); #1;
        chk("C_rsp_valid", rsp_valid, 1); chk("C_rsp_err", rsp_err, 0);

        // Read, 4 beats from 0x3F8, crossing the 1 KB boundary
        cyc(); cmd(1'b0, 32'h3F8, 4'd3); #1;
        chk("D_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("D_htrans0", htrans, 2); chk("D_haddr0", haddr, 32'h3F8);
        cyc(); hrdata = 32'hB0; #1;
        chk("D_htrans1", htrans, 3); chk("D_haddr1", haddr, 32'h3FC); chk("D_rv0", rd_valid, 1);
        cyc(); hrdata = 32'hB1; #1;
        chk("D_htrans2_nonseq", htrans, 2); chk("D_haddr2", haddr, 32'h400);
        chk("D_rv1", rd_valid, 1); chk("D_hburst_incr", hburst, 1);
        cyc(); hrdata = 32'hB2; #1;
        chk("D_htrans3", htrans, 3); chk("D_haddr3", haddr, 32'h404);
        chk("D_rv2", rd_valid, 1); chk("D_rd2", rd_data, 32'hB2);
        cyc(); hrdata = 32'hB3; #1;
        chk("D_rv3", rd_valid, 1); chk("D_rl3", rd_last, 1); chk("D_rd3", rd_data, 32'hB3);
        cyc(); #1;
        chk("D_rsp_valid", rsp_valid, 1); chk("D_rsp_err", rsp_err, 0);

        // Write, 8 beats from 0x500, ERROR on the data phase of beat 3
        cyc(); cmd(1'b1, 32'h500, 4'd7); wr_valid = 1'b1; wr_data = 32'h100; #1;
        chk("E_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("E_htrans0", htrans, 2); chk("E_haddr0", haddr, 32'h500); chk("E_wr_ready0", wr_ready, 1);
        cyc(); wr_data = 32'h101; #1;
        chk("E_htrans1", htrans, 3); chk("E_haddr1", haddr, 32'h504);
        cyc(); wr_data = 32'h102; #1;
        chk("E_haddr2", haddr, 32'h508);
        cyc(); wr_data = 32'h103; #1;
        chk("E_haddr3", haddr, 32'h50C); chk("E_wr_ready3", wr_ready, 1);
        cyc(); wr_data = 32'h104; hready = 1'b0; hresp = 1'b1; #1;
        chk("E_err1_wr_ready", wr_ready, 0); chk("E_err1_hwdata", hwdata, 32'h103);
        cyc(); hready = 1'b1; #1;
        chk("E_err2_htrans", htrans, 0); chk("E_err2_wr_ready", wr_ready, 0);
        cyc(); hresp = 1'b0; #1;
        chk("E_drain1", wr_ready, 1); chk("E_drain_htrans", htrans, 0);
        cyc(); wr_valid = 1'b0; #1;
        chk("E_drain_stall", wr_ready, 0);
        cyc(); wr_valid = 1'b1; #1;
        chk("E_drain2", wr_ready, 1);
        cyc(); #1;
        chk("E_drain3", wr_ready, 1);
        cyc(); #1;
        chk("E_drain4", wr_ready, 1); chk("E_drain4_htrans", htrans, 0);
        cyc(); #1;
        chk("E_drain_done", wr_ready, 0); chk("E_no_early_rsp", rsp_valid, 0);
        cyc(); wr_valid = 1'b0; #1;
        chk("E_rsp_valid", rsp_valid, 1); chk("E_rsp_err", rsp_err, 1);

        // Reset asserted mid-burst, then a fresh single read
        cyc(); cmd(1'b0, 32'h600, 4'd3); #1;
        chk("F_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("F_htrans0", htrans, 2); chk("F_haddr0", haddr, 32'h600);
        cyc(); #1;
        chk("F_htrans1", htrans, 3);
        reset_reset_n = 1'b0; #1;
        chk("F_rst_htrans", htrans, 0); chk("F_rst_haddr", haddr, 0);
        chk("F_rst_cmd_ready", cmd_ready, 0); chk("F_rst_rsp", rsp_valid, 0);
        cyc(); reset_reset_n = 1'b1; #1;
        chk("F_no_rsp", rsp_valid, 0);
        cyc(); cmd(1'b0, 32'h700, 4'd0); #1;
        chk("F_cmd_ready_after", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("F_htrans", htrans, 2); chk("F_haddr", haddr, 32'h700); chk("F_hburst", hburst, 0);
        cyc(); hrdata = 32'hC5; #1;
        chk("F_rv", rd_valid, 1); chk("F_rl", rd_last, 1); chk("F_rd", rd_data, 32'hC5);
        cyc(); #1;
        chk("F_rsp_valid", rsp_valid, 1); chk("F_rsp_err", rsp_err, 0);

        // Single read whose only beat returns ERROR: error wins over last beat
        cyc(); cmd(1'b0, 32'h800, 4'd0); #1;
        chk("G_cmd_ready", cmd_ready, 1);
        cyc(); cmd_valid = 1'b0; #1;
        chk("G_htrans", htrans, 2);
        cyc(); hready = 1'b0; hresp = 1'b1; #1;
        chk("G_err1_rv", rd_valid, 0);
        cyc(); hready = 1'b1; #1;
        chk("G_err2_rv", rd_valid, 0); chk("G_err2_rl", rd_last, 0); chk("G_err2_htrans", htrans, 0);
        cyc(); hresp = 1'b0; #1;
        chk("G_no_early_rsp", rsp_valid, 0);
        cyc(); #1;
        chk("G_rsp_valid", rsp_valid, 1); chk("G_rsp_err", rsp_err, 1);
        cyc(); #1;
        chk("G_cmd_ready", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
